// File: rtl/sprite_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sprite_scan_pkg
// Description : Shared definitions for the sprite line scheduler: FSM state
//               encoding, sprite attribute word field offsets, the number of
//               RAM words per sprite and the slot record layout.
// Revision    : 1.0 - initial release
// ============================================================================
package sprite_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

    // ctrl word (even address) fields
    localparam int SPR_CTRL_ENABLE_BIT = 0;
    localparam int SPR_DEPTH_LSB       = 16;
    localparam int SPR_DEPTH_MSB       = 19;

    // pos word (odd address) fields
    localparam int SPR_X_LSB           = 0;
    localparam int SPR_X_MSB           = 15;
    localparam int SPR_Y_LSB           = 16;
    localparam int SPR_Y_MSB           = 31;

    localparam int WORDS_PER_SPRITE    = 2;

    // Per-slot attributes that do not depend on SPRITE_HEIGHT
    typedef struct packed {
        logic [6:0]  id;
        logic [15:0] x;
        logic [3:0]  depth;
    } slot_rec_t;

endpackage
`default_nettype wire

// File: rtl/sprite_line_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : sprite_line_scheduler_if
// Description : Bus bundle between the scheduler, the sprite attribute RAM
//               read port and the renderer's per-line slot buffer.
//               master : scheduler side (drives RAM address, slot writes)
//               slave  : RAM / slot buffer side (drives RAM read data)
// Signals     : spr_clk, spr_addr[7:0], spr_data[127:0],
//               slot_we, slot_addr, slot_id[6:0], slot_x[15:0],
//               slot_row, slot_depth[3:0]
// Revision    : 1.0 - initial release
// ============================================================================
interface sprite_line_scheduler_if #(
    parameter int MAX_PER_LINE  = 8,
    parameter int SPRITE_HEIGHT = 16
);
    localparam int SLOT_W = $clog2(MAX_PER_LINE);
    localparam int ROW_W  = $clog2(SPRITE_HEIGHT);

    logic              spr_clk;
    logic [7:0]        spr_addr;
    logic [127:0]      spr_data;

    logic              slot_we;
    logic [SLOT_W-1:0] slot_addr;
    logic [6:0]        slot_id;
    logic [15:0]       slot_x;
    logic [ROW_W-1:0]  slot_row;
    logic [3:0]        slot_depth;

    modport master (
        output spr_clk, spr_addr,
        input  spr_data,
        output slot_we, slot_addr, slot_id, slot_x, slot_row, slot_depth
    );

    modport slave (
        input  spr_clk, spr_addr,
        output spr_data,
        input  slot_we, slot_addr, slot_id, slot_x, slot_row, slot_depth
    );

endinterface
`default_nettype wire

// File: rtl/sprite_visibility_check.sv
`default_nettype none
// ============================================================================
// Module      : sprite_visibility_check
// Description : Combinational test of whether a sprite covers the target
//               line. diff = (target - y) mod 2^16; visible when enabled and
//               diff < SPRITE_HEIGHT. Negative y wraps to a large diff for
//               lines above the sprite, so sprites clip at the screen top.
// Ports       : i_target[15:0]  target line (zero-extended)
//               i_y[15:0]       sprite y
//               i_enable        sprite enable bit
//               o_visible       sprite covers target line
//               o_row           row of sprite on target line
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_visibility_check #(
    parameter int SPRITE_HEIGHT = 16,
    localparam int ROW_W = $clog2(SPRITE_HEIGHT)
) (
    input  wire logic [15:0]      i_target,
    input  wire logic [15:0]      i_y,
    input  wire logic             i_enable,
    output logic                  o_visible,
    output logic [ROW_W-1:0]      o_row
);
    logic [15:0] w_diff;

    assign w_diff    = i_target - i_y;
    assign o_visible = i_enable && (w_diff < 16'(SPRITE_HEIGHT));
    assign o_row     = w_diff[ROW_W-1:0];

endmodule
`default_nettype wire

// File: rtl/sprite_line_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sprite_line_scheduler
// Description : Once per scanline, reads every sprite's ctrl/pos word pair
//               from the sprite attribute RAM and writes the sprites visible
//               on the next line into the renderer's slot buffer.
//               Optional macro SPRITE_SCAN_EARLY_EXIT_EN: stop reading sprites
//               after the first visible sprite that finds the slots full.
// Ports       : clk, reset (async, active-low)
//               h_pos, v_pos      display counters
//               sprites_enable    global sprite enable
//               bus (master)      sprite RAM read port + slot buffer writes
//               slot_count        valid slots in the current list
//               scan_busy         scan in progress
//               scan_done         one-cycle pulse at scan end
//               overflow          more sprites visible than slots
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_line_scheduler
    import sprite_scan_pkg::*;
#(
    parameter int HCOUNT_WIDTH  = 10,
    parameter int VCOUNT_WIDTH  = 10,
    parameter int NUM_SPRITES   = 128,
    parameter int SPRITE_HEIGHT = 16,
    parameter int MAX_PER_LINE  = 8,
    parameter int SCAN_START_H  = 0,
    parameter int V_TOTAL       = 525
) (
    input  wire logic                          clk,
    input  wire logic                          reset,
    input  wire logic [HCOUNT_WIDTH-1:0]       h_pos,
    input  wire logic [VCOUNT_WIDTH-1:0]       v_pos,
    input  wire logic                          sprites_enable,
    sprite_line_scheduler_if.master            bus,
    output logic [$clog2(MAX_PER_LINE):0]      slot_count,
    output logic                               scan_busy,
    output logic                               scan_done,
    output logic                               overflow
);
    localparam int       c_SLOT_W = $clog2(MAX_PER_LINE);
    localparam int       c_ROW_W  = $clog2(SPRITE_HEIGHT);
    localparam int       c_CNT_W  = c_SLOT_W + 1;
    localparam bit [8:0] c_LAST   = 9'(WORDS_PER_SPRITE * NUM_SPRITES);

    scan_state_t         r_state;
    logic [8:0]          r_issue_cnt;   // next RAM address to issue
    logic                r_issue_vld;   // r_spr_addr carries a live request
    logic [7:0]          r_spr_addr;
    logic                r_data_vld;    // spr_data holds a live word this cycle
    logic [7:0]          r_data_addr;   // address that produced spr_data
    logic                r_ctrl_en;
    logic [3:0]          r_ctrl_depth;
    logic [15:0]         r_target;
    logic                r_drain;
    logic                r_slot_we;
    logic [c_SLOT_W-1:0] r_slot_addr;
    slot_rec_t           r_slot;
    logic [c_ROW_W-1:0]  r_slot_row;
    logic [c_CNT_W-1:0]  r_slot_count;
    logic                r_scan_busy;
    logic                r_scan_done;
    logic                r_overflow;

    logic                w_start;
    logic [15:0]         w_target;
    logic                w_visible;
    logic [c_ROW_W-1:0]  w_row;
    logic                w_hit;
    logic                w_full;
    logic                w_unused_data;

    assign w_start  = (h_pos == HCOUNT_WIDTH'(SCAN_START_H)) && sprites_enable;
    assign w_target = (v_pos == VCOUNT_WIDTH'(V_TOTAL - 1)) ? 16'd0
                                                            : 16'(v_pos) + 16'd1;

    sprite_visibility_check #(
        .SPRITE_HEIGHT (SPRITE_HEIGHT)
    ) u_vis (
        .i_target  (r_target),
        .i_y       (bus.spr_data[SPR_Y_MSB:SPR_Y_LSB]),
        .i_enable  (r_ctrl_en),
        .o_visible (w_visible),
        .o_row     (w_row)
    );

    // A pos word is on spr_data whenever the live data came from an odd address
    assign w_hit  = r_data_vld && r_data_addr[0] && w_visible;
    assign w_full = (r_slot_count == c_CNT_W'(MAX_PER_LINE));

    assign w_unused_data = ^bus.spr_data[127:32];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_issue_cnt  <= '0;
            r_issue_vld  <= 1'b0;
            r_spr_addr   <= '0;
            r_data_vld   <= 1'b0;
            r_data_addr  <= '0;
            r_ctrl_en    <= 1'b0;
            r_ctrl_depth <= '0;
            r_target     <= '0;
            r_drain      <= 1'b0;
            r_slot_we    <= 1'b0;
            r_slot_addr  <= '0;
            r_slot       <= '0;
            r_slot_row   <= '0;
            r_slot_count <= '0;
            r_scan_busy  <= 1'b0;
            r_scan_done  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_slot_we   <= 1'b0;
            r_scan_done <= 1'b0;
            r_issue_vld <= 1'b0;
            r_data_vld  <= r_issue_vld;
            r_data_addr <= r_spr_addr;

            if (r_data_vld && !r_data_addr[0]) begin
                r_ctrl_en    <= bus.spr_data[SPR_CTRL_ENABLE_BIT];
                r_ctrl_depth <= bus.spr_data[SPR_DEPTH_MSB:SPR_DEPTH_LSB];
            end

            // Count trails the write strobe by one cycle; the next sprite's
            // pos word is two cycles behind, so it always sees the new count.
            if (r_slot_we) begin
                r_slot_count <= r_slot_count + c_CNT_W'(1);
            end

            if (w_hit) begin
                if (!w_full) begin
                    r_slot_we    <= 1'b1;
                    r_slot_addr  <= r_slot_count[c_SLOT_W-1:0];
                    r_slot.id    <= r_data_addr[7:1];
                    r_slot.x     <= bus.spr_data[SPR_X_MSB:SPR_X_LSB];
                    r_slot.depth <= r_ctrl_depth;
                    r_slot_row   <= w_row;
                end else begin
                    r_overflow   <= 1'b1;
                end
            end

            if (w_start) begin
                // Start from any state: a start while busy abandons the old
                // line, and the cleared valids keep in-flight data from
                // reaching the slot buffer.
                r_state      <= ST_SCAN;
                r_issue_cnt  <= '0;
                r_data_vld   <= 1'b0;
                r_slot_we    <= 1'b0;
                r_slot_count <= '0;
                r_overflow   <= 1'b0;
                r_scan_busy  <= 1'b1;
                r_drain      <= 1'b0;
                r_target     <= w_target;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_scan_busy <= 1'b0;
                    end
                    ST_SCAN: begin
`ifdef SPRITE_SCAN_EARLY_EXIT_EN
                        if (w_hit && w_full) begin
                            r_state <= ST_DRAIN;
                            r_drain <= 1'b0;
                        end else
`endif
                        if (r_issue_cnt == c_LAST) begin
                            r_state <= ST_DRAIN;
                            r_drain <= 1'b0;
                        end else begin
                            r_spr_addr  <= r_issue_cnt[7:0];
                            r_issue_vld <= 1'b1;
                            r_issue_cnt <= r_issue_cnt + 9'd1;
                        end
                    end
                    ST_DRAIN: begin
                        if (r_drain) begin
                            r_state     <= ST_DONE;
                            r_scan_busy <= 1'b0;
                            r_scan_done <= 1'b1;
                        end else begin
                            r_drain <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.spr_clk    = clk;
    assign bus.spr_addr   = r_spr_addr;
    assign bus.slot_we    = r_slot_we;
    assign bus.slot_addr  = r_slot_addr;
    assign bus.slot_id    = r_slot.id;
    assign bus.slot_x     = r_slot.x;
    assign bus.slot_row   = r_slot_row;
    assign bus.slot_depth = r_slot.depth;
    assign slot_count     = r_slot_count;
    assign scan_busy      = r_scan_busy;
    assign scan_done      = r_scan_done;
    assign overflow       = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_sprite_line_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_line_scheduler
// Description : Directed self-checking bench for sprite_line_scheduler with a
//               registered sprite RAM model and a slot-write monitor.
//               Honours SPRITE_SCAN_EARLY_EXIT_EN for the overflow timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_line_scheduler;

    logic       clk;
    logic       rst_n;
    logic [9:0] h_pos;
    logic [9:0] v_pos;
    logic       sprites_enable;
    logic [3:0] slot_count;
    logic       scan_busy;
    logic       scan_done;
    logic       overflow;

    int tests;
    int fails;

    sprite_line_scheduler_if #(.MAX_PER_LINE(8), .SPRITE_HEIGHT(16)) bus ();

    sprite_line_scheduler dut (
        .clk            (clk),
        .reset          (rst_n),
        .h_pos          (h_pos),
        .v_pos          (v_pos),
        .sprites_enable (sprites_enable),
        .bus            (bus),
        .slot_count     (slot_count),
        .scan_busy      (scan_busy),
        .scan_done      (scan_done),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered sprite RAM, one cycle read latency
    logic [127:0] mem [0:255];
    always @(posedge bus.spr_clk) bus.spr_data <= mem[bus.spr_addr];

    typedef struct packed {
        logic [2:0]  addr;
        logic [6:0]  id;
        logic [15:0] x;
        logic [3:0]  row;
        logic [3:0]  depth;
    } wr_t;
    wr_t wrq[$];

    always @(posedge clk) begin
        #1;
        if (bus.slot_we === 1'b1)
            wrq.push_back({bus.slot_addr, bus.slot_id, bus.slot_x, bus.slot_row, bus.slot_depth});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    task automatic set_sprite(input int i, input bit en, input logic [3:0] depth,
                              input logic [15:0] x, input logic [15:0] y);
        mem[2*i]   = (128'(depth) << 16) | 128'(en);
        mem[2*i+1] = 128'({y, x});
    endtask

    // Pulse the start condition for one cycle and count edges (start edge = 1)
    // until scan_done is seen; 0 means it never came.
    task automatic run_scan(output int cyc);
        int  k;
        bit  seen;
        k    = 0;
        seen = 1'b0;
        h_pos = 10'd0;
        while (!seen && k < 400) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            h_pos = 10'd5;
            if (scan_done === 1'b1) seen = 1'b1;
        end
        cyc = seen ? k : 0;
    endtask

    int cyc;
    int k;
    int exp_cyc;
    bit seen;
    logic [7:0] addr_after_restart;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        h_pos = 10'd5;
        v_pos = 10'd7;
        sprites_enable = 1'b1;
        clear_mem();
        repeat (3) @(negedge clk);

        // ---- reset values
        chk("rst_slot_we",    bus.slot_we, 0);
        chk("rst_spr_addr",   bus.spr_addr, 0);
        chk("rst_slot_count", slot_count, 0);
        chk("rst_scan_busy",  scan_busy, 0);
        chk("rst_scan_done",  scan_done, 0);
        chk("rst_overflow",   overflow, 0);
        chk("rst_slot_id",    bus.slot_id, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ---- basic scan: sprites 0..3, x=y=8i, depth 15-i, target line 8
        for (int i = 0; i < 4; i++) set_sprite(i, 1'b1, 4'(15 - i), 16'(8 * i), 16'(8 * i));
        v_pos = 10'd7;
        wrq.delete();
        run_scan(cyc);
        chk("t1_cycles",   cyc, 260);
        chk("t1_nwrites",  wrq.size(), 2);
        if (wrq.size() == 2) begin
            chk("t1_w0", wrq[0], {3'd0, 7'd0, 16'd0, 4'd8, 4'd15});
            chk("t1_w1", wrq[1], {3'd1, 7'd1, 16'd8, 4'd0, 4'd14});
        end
        chk("t1_count",    slot_count, 2);
        chk("t1_overflow", overflow, 0);
        @(negedge clk);
        chk("t1_busy_after", scan_busy, 0);

        // ---- start condition with sprites disabled: nothing happens
        sprites_enable = 1'b0;
        wrq.delete();
        h_pos = 10'd0;
        @(posedge clk);
        @(negedge clk);
        h_pos = 10'd5;
        chk("t6_busy_now", scan_busy, 0);
        repeat (5) @(negedge clk);
        chk("t6_busy_later", scan_busy, 0);
        chk("t6_count",      slot_count, 2);
        chk("t6_nwrites",    wrq.size(), 0);
        sprites_enable = 1'b1;

        // ---- negative y clipped at the top, target line wraps to 0
        clear_mem();
        set_sprite(5, 1'b1, 4'd3, 16'h1234, 16'hFFF8);
        v_pos = 10'd524;
        wrq.delete();
        run_scan(cyc);
        chk("t2_cycles",  cyc, 260);
        chk("t2_nwrites", wrq.size(), 1);
        if (wrq.size() == 1)
            chk("t2_w0", wrq[0], {3'd0, 7'd5, 16'h1234, 4'd8, 4'd3});
        chk("t2_count",   slot_count, 1);

        // ---- ten visible sprites, eight slots
        clear_mem();
        for (int i = 0; i < 10; i++) set_sprite(i, 1'b1, 4'd1, 16'(i), 16'd0);
        v_pos = 10'd2;
        wrq.delete();
        repeat (3) @(negedge clk);
        run_scan(cyc);
`ifdef SPRITE_SCAN_EARLY_EXIT_EN
        exp_cyc = 23;
`else
        exp_cyc = 260;
`endif
        chk("t3_cycles",   cyc, exp_cyc);
        chk("t3_nwrites",  wrq.size(), 8);
        if (wrq.size() == 8) begin
            chk("t3_w0", wrq[0], {3'd0, 7'd0, 16'd0, 4'd3, 4'd1});
            chk("t3_w7", wrq[7], {3'd7, 7'd7, 16'd7, 4'd3, 4'd1});
        end
        chk("t3_count",    slot_count, 8);
        chk("t3_overflow", overflow, 1);

        // ---- restart 50 cycles into a scan, sprite 23 write in flight
        clear_mem();
        set_sprite(22, 1'b1, 4'd2, 16'd100, 16'd8);
        set_sprite(23, 1'b1, 4'd4, 16'd200, 16'd8);
        v_pos = 10'd7;
        repeat (3) @(negedge clk);
        h_pos = 10'd0;
        repeat (50) begin
            @(posedge clk);
            @(negedge clk);
            h_pos = 10'd5;
        end
        chk("t4_pre_count", slot_count, 1);
        wrq.delete();
        h_pos = 10'd0;
        @(posedge clk);
        @(negedge clk);
        h_pos = 10'd5;
        chk("t4_abort_we",    bus.slot_we, 0);
        chk("t4_abort_count", slot_count, 0);
        chk("t4_abort_busy",  scan_busy, 1);
        k = 1;
        seen = 1'b0;
        addr_after_restart = 8'hFF;
        while (!seen && k < 400) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (k == 2) addr_after_restart = bus.spr_addr;
            if (scan_done === 1'b1) seen = 1'b1;
        end
        chk("t4_restart_addr", addr_after_restart, 0);
        chk("t4_cycles",       seen ? k : 0, 260);
        chk("t4_nwrites",      wrq.size(), 2);
        if (wrq.size() == 2) begin
            chk("t4_w0", wrq[0], {3'd0, 7'd22, 16'd100, 4'd0, 4'd2});
            chk("t4_w1", wrq[1], {3'd1, 7'd23, 16'd200, 4'd0, 4'd4});
        end
        chk("t4_count", slot_count, 2);

        // ---- asynchronous reset while a slot write is on the bus
        clear_mem();
        set_sprite(13, 1'b1, 4'd9, 16'd77, 16'd8);
        repeat (3) @(negedge clk);
        h_pos = 10'd0;
        repeat (31) begin
            @(posedge clk);
            @(negedge clk);
            h_pos = 10'd5;
        end
        chk("t5_pre_we", bus.slot_we, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_we",       bus.slot_we, 0);
        chk("t5_spr_addr", bus.spr_addr, 0);
        chk("t5_count",    slot_count, 0);
        chk("t5_busy",     scan_busy, 0);
        chk("t5_done",     scan_done, 0);
        chk("t5_slot_x",   bus.slot_x, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wrq.delete();
        repeat (10) @(negedge clk);
        chk("t5_idle_busy", scan_busy, 0);
        chk("t5_idle_addr", bus.spr_addr, 0);
        chk("t5_idle_wr",   wrq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_line_scheduler.md
Name: sprite_line_scheduler

Overview:
- Scans the sprite attribute RAM once per scanline and builds the list of sprites visible on the next line.
- Writes the list into the renderer's per-line slot buffer.
- Sole sequencer of the sprite RAM read port (spr_clk/spr_addr/spr_data). Sits between the display controller counters and the sprite pixel fetch stage of the renderer.

Parameters:
- HCOUNT_WIDTH, 10, width of h_pos
- VCOUNT_WIDTH, 10, width of v_pos
- NUM_SPRITES, 128, sprites in RAM; two 128-bit words each
- SPRITE_HEIGHT, 16, sprite height in lines; power of two
- MAX_PER_LINE, 8, slot buffer depth; power of two
- SCAN_START_H, 0, h_pos value that starts a scan
- V_TOTAL, 525, total lines per frame

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low system reset (asserted when 0)
- h_pos  in  HCOUNT_WIDTH  display controller horizontal count
- v_pos  in  VCOUNT_WIDTH  display controller vertical count
- sprites_enable  in  1  global sprite enable
- spr_clk  out  1  sprite RAM clock, driven directly by clk
- spr_addr  out  8  sprite RAM word address
- spr_data  in  128  sprite RAM read data, registered, 1-cycle latency
- slot_we  out  1  slot buffer write strobe
- slot_addr  out  log2(MAX_PER_LINE)  slot index
- slot_id  out  7  sprite number
- slot_x  out  16  sprite x, from pos word [15:0]
- slot_row  out  log2(SPRITE_HEIGHT)  row of sprite on target line
- slot_depth  out  4  from ctrl word [19:16]
- slot_count  out  log2(MAX_PER_LINE)+1  valid slots for current list
- scan_busy  out  1  scan in progress
- scan_done  out  1  one-cycle pulse at scan end
- overflow  out  1  more than MAX_PER_LINE sprites visible on the line

Behaviour:
- Reset values: all outputs 0, state IDLE, spr_addr 0.
- Start event: h_pos == SCAN_START_H while sprites_enable is 1.
- Target line: v_pos+1, or 0 when v_pos == V_TOTAL-1.
- Word layout:
  - ctrl = word 2i: bit0 enable, [19:16] depth.
  - pos = word 2i+1: [15:0] x, [31:16] y.
- States: IDLE -> SCAN -> DRAIN -> DONE -> IDLE.
- IDLE, on start: clear slot_count and overflow, idx=0, scan_busy=1, enter SCAN.
- SCAN issues addresses back-to-back, one per cycle: 2*idx, then 2*idx+1, then idx+1. Throughput is 2 cycles per sprite.
- Pipeline timing for an address pair issued at cycle n:
  - ctrl data latched at n+1.
  - pos data arrives at n+2; visibility evaluated that cycle.
  - slot write registered at n+3.
- Visibility test:
  - diff = ({16-bit zero-extended target} - y) mod 2^16.
  - Visible iff enable bit is set and diff < SPRITE_HEIGHT.
  - Negative y (two's complement) therefore clips at the top of the screen.
  - slot_row = diff[log2(SPRITE_HEIGHT)-1:0].
- On visible and slot_count < MAX_PER_LINE:
  - slot_we=1 for one cycle, slot_addr=slot_count.
  - slot_id/x/row/depth valid in the same cycle.
  - slot_count increments the following cycle.
- On visible and slot_count == MAX_PER_LINE: no write; overflow=1.
- After the last address (2*NUM_SPRITES-1) is issued: DRAIN for 2 cycles to flush the pipeline, then DONE.
- DONE: scan_done=1 for one cycle, scan_busy=0, then IDLE.
- slot_count and overflow hold until the next start.
- Start while busy (new line): abort, discard pipeline contents, restart from idx 0 with counts cleared. No stale slot write may occur.
- sprites_enable falling mid-scan: current scan completes; no new scan starts.
- Reset asserted mid-scan: immediate return to reset values; slot_we deasserted the same instant.
- slot_we is never asserted outside SCAN/DRAIN.

Optional Feature:
- Macro: SPRITE_SCAN_EARLY_EXIT_EN.
- Defined: the first visible sprite found while slots are full sets overflow, then the block flushes and goes directly to DONE. Remaining sprites are not read.
- Undefined: the scan always covers all NUM_SPRITES. Cycle count per scan is fixed at 2*NUM_SPRITES+4.

Decomposition:
- Shared package sprite_scan_pkg holds:
  - State encoding.
  - Field offsets: SPR_CTRL_ENABLE_BIT, SPR_DEPTH_LSB/MSB, SPR_X_LSB/MSB, SPR_Y_LSB/MSB.
  - Word-per-sprite constant (2).
  - Slot record typedef.
- One natural sub-module: sprite_visibility_check. It is combinational: target, y, enable -> visible, row.

Test Plan:
- Sprites 0-3 enabled with depth 15-i and x=y=8i; rest zero; v_pos=7, h_pos=0 -> two slot writes: (id0, x0, row8, depth15), (id1, x8, row0, depth14); slot_count=2; overflow=0; scan_done at cycle 2*128+4.
- Sprite 5 enabled with y=0xFFF8; target line 0 (v_pos=V_TOTAL-1) -> one write, id5, row 8.
- Ten sprites with y=0 enabled; target 3 -> eight writes (ids 0-7), overflow=1, slot_count=8. With EARLY_EXIT_EN, scan_done at the 9th hit plus flush; without it, scan_done at the fixed count.
- Start pulse repeated 50 cycles into a scan -> counts cleared, scan restarts at spr_addr 0, no writes from the aborted scan.
- Reset driven low mid-scan at cycle 30 -> all outputs 0 immediately; with reset high and no start, state stays IDLE.
- sprites_enable=0 at a start event -> no scan, scan_busy stays 0, slot_count unchanged.
